// File: rtl/stb_pkg.sv
// -----------------------------------------------------------------------------
// stb_pkg
// Shared helpers for the store buffer: byte-lane count and word addressing.
// No ports; imported by stb_fwd and stb_fwd_sel.
// -----------------------------------------------------------------------------
package stb_pkg;

  localparam int unsigned BYTE_W = 32'd8;

  // log2 of a power-of-two value (number of right shifts to reach 1).
  function automatic int unsigned log2_pow2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 32'd0;
    x = v;
    while (x > 32'd1) begin
      x = x >> 1;
      r = r + 32'd1;
    end
    return r;
  endfunction

  // Number of byte lanes in a data word.
  function automatic int unsigned lane_count(input int unsigned data_width);
    return data_width / BYTE_W;
  endfunction

  // Byte address to word address: drop the in-word byte offset.
  function automatic logic [63:0] word_addr(input logic [63:0] addr, input int unsigned lanes);
    return addr >> log2_pow2(lanes);
  endfunction

endpackage

// File: rtl/stb_fwd_if.sv
// -----------------------------------------------------------------------------
// stb_fwd_if
// Bundle of the store, load-probe, commit and status signals of stb_fwd.
//   master : core/cache side (drives i_*, observes o_*)
//   slave  : store buffer side (observes i_*, drives o_*)
// Parameters: ADDR_WIDTH, DATA_WIDTH (multiple of 8), N_LINES (sizes o_count).
// -----------------------------------------------------------------------------
interface stb_fwd_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int N_LINES    = 4
);
  localparam int LANES = DATA_WIDTH / 8;

  logic                     i_st_valid;
  logic                     o_st_ready;
  logic [ADDR_WIDTH-1:0]    i_st_addr;
  logic [DATA_WIDTH-1:0]    i_st_data;
  logic [LANES-1:0]         i_st_mask;
  logic                     i_ld_valid;
  logic [ADDR_WIDTH-1:0]    i_ld_addr;
  logic [LANES-1:0]         i_ld_mask;
  logic                     o_ld_hit;
  logic                     o_ld_partial;
  logic [DATA_WIDTH-1:0]    o_ld_data;
  logic                     o_cm_valid;
  logic                     i_cm_ready;
  logic [ADDR_WIDTH-1:0]    o_cm_addr;
  logic [DATA_WIDTH-1:0]    o_cm_data;
  logic [LANES-1:0]         o_cm_mask;
  logic                     i_fence;
  logic                     o_empty;
  logic [$clog2(N_LINES):0] o_count;

  modport master (
    output i_st_valid, i_st_addr, i_st_data, i_st_mask,
    output i_ld_valid, i_ld_addr, i_ld_mask,
    output i_cm_ready, i_fence,
    input  o_st_ready, o_ld_hit, o_ld_partial, o_ld_data,
    input  o_cm_valid, o_cm_addr, o_cm_data, o_cm_mask,
    input  o_empty, o_count
  );

  modport slave (
    input  i_st_valid, i_st_addr, i_st_data, i_st_mask,
    input  i_ld_valid, i_ld_addr, i_ld_mask,
    input  i_cm_ready, i_fence,
    output o_st_ready, o_ld_hit, o_ld_partial, o_ld_data,
    output o_cm_valid, o_cm_addr, o_cm_data, o_cm_mask,
    output o_empty, o_count
  );
endinterface

// File: rtl/stb_fwd_sel.sv
// -----------------------------------------------------------------------------
// stb_fwd_sel
// Per-lane youngest-match select over the store queue.
//   valid_i/waddr_i/data_i/mask_i : queue contents, indexed by slot
//   head_i     : slot of the oldest entry
//   ld_waddr_i : load word address
//   covered_o  : lanes supplied by some matching entry
//   data_o     : per lane, the byte of the youngest matching entry (0 if none)
// -----------------------------------------------------------------------------
module stb_fwd_sel
  import stb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int N_LINES    = 4
) (
  input  logic [N_LINES-1:0]                     valid_i,
  input  logic [N_LINES-1:0][ADDR_WIDTH-1:0]     waddr_i,
  input  logic [N_LINES-1:0][DATA_WIDTH-1:0]     data_i,
  input  logic [N_LINES-1:0][DATA_WIDTH/8-1:0]   mask_i,
  input  logic [$clog2(N_LINES)-1:0]             head_i,
  input  logic [ADDR_WIDTH-1:0]                  ld_waddr_i,
  output logic [DATA_WIDTH/8-1:0]                covered_o,
  output logic [DATA_WIDTH-1:0]                  data_o
);
  localparam int LANES = int'(lane_count(DATA_WIDTH));
  localparam int IW    = $clog2(N_LINES);

  logic [IW-1:0] idx;

  // Walk slots oldest to youngest; valid entries are contiguous from head, so
  // a later match overriding an earlier one leaves the youngest per lane.
  always_comb begin
    covered_o = '0;
    data_o    = '0;
    idx       = '0;
    for (int k = 0; k < N_LINES; k++) begin
      idx = head_i + IW'(k);
      if (valid_i[idx] && (waddr_i[idx] == ld_waddr_i)) begin
        for (int b = 0; b < LANES; b++) begin
          if (mask_i[idx][b]) begin
            covered_o[b]      = 1'b1;
            data_o[8*b +: 8]  = data_i[idx][8*b +: 8];
          end else begin
            covered_o[b]      = covered_o[b];
          end
        end
      end else begin
        covered_o = covered_o;
      end
    end
  end
endmodule

// File: rtl/stb_fwd.sv
// -----------------------------------------------------------------------------
// stb_fwd
// Store buffer between MEM and the L1 D-cache: in-order circular queue with
// byte-granular store-to-load forwarding and a valid/ready commit channel.
//   clk  : clock
//   rst  : asynchronous active-high reset (drops all pending entries)
//   bus  : stb_fwd_if.slave (store in, load probe, commit out, fence, status)
// Build option: define STB_COALESCE_EN to merge a store into the newest entry
// when the word addresses match.
// -----------------------------------------------------------------------------
module stb_fwd
  import stb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int N_LINES    = 4
) (
  input  logic     clk,
  input  logic     rst,
  stb_fwd_if.slave bus
);
  localparam int LANES      = int'(lane_count(DATA_WIDTH));
  localparam int LANE_SHIFT = int'(log2_pow2(LANES));
  localparam int IW         = $clog2(N_LINES);
  localparam int CW         = IW + 1;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] data;
    logic [LANES-1:0]      mask;
  } entry_t;

  entry_t [N_LINES-1:0] ent_q, ent_d;
  logic [IW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;

  logic [ADDR_WIDTH-1:0] st_waddr, ld_waddr;
  logic                  st_ready, st_fire, st_alloc, cm_fire;
  entry_t                head_ent;

  logic [N_LINES-1:0]                   ent_valid;
  logic [N_LINES-1:0][ADDR_WIDTH-1:0]   ent_waddr;
  logic [N_LINES-1:0][DATA_WIDTH-1:0]   ent_data;
  logic [N_LINES-1:0][LANES-1:0]        ent_mask;
  logic [LANES-1:0]                     fwd_cov, ld_cov;
  logic [DATA_WIDTH-1:0]                fwd_data, ld_data;
  logic                                 ld_hit, ld_partial;

  assign st_waddr = ADDR_WIDTH'(word_addr(64'(bus.i_st_addr), LANES));
  assign ld_waddr = ADDR_WIDTH'(word_addr(64'(bus.i_ld_addr), LANES));
  assign head_ent = ent_q[head_q];
  assign cm_fire  = head_ent.valid && bus.i_cm_ready;
  assign st_fire  = bus.i_st_valid && st_ready;

`ifdef STB_COALESCE_EN
  logic [IW-1:0] newest_idx;
  logic          merge_hit;
  logic          st_merge;

  // A merge may not target the entry leaving through the commit port this cycle.
  assign newest_idx = tail_q - IW'(1);
  assign merge_hit  = (count_q != '0) && ent_q[newest_idx].valid &&
                      (ent_q[newest_idx].waddr == st_waddr) &&
                      !((newest_idx == head_q) && cm_fire);
  assign st_ready   = !bus.i_fence && ((count_q < CW'(N_LINES)) || merge_hit);
  assign st_merge   = st_fire && merge_hit;
  assign st_alloc   = st_fire && !merge_hit;
`else
  // Full is judged on count alone; a same-cycle commit does not free a slot early.
  assign st_ready   = !bus.i_fence && (count_q < CW'(N_LINES));
  assign st_alloc   = st_fire;
`endif

  // Queue state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Next queue state: retire the head, allocate or merge the incoming store.
  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    if (cm_fire) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + IW'(1);
    end else begin
      head_d              = head_q;
    end
    if (st_alloc) begin
      ent_d[tail_q].valid = 1'b1;
      ent_d[tail_q].waddr = st_waddr;
      ent_d[tail_q].data  = bus.i_st_data;
      ent_d[tail_q].mask  = bus.i_st_mask;
      tail_d              = tail_q + IW'(1);
    end else begin
      tail_d              = tail_q;
    end
`ifdef STB_COALESCE_EN
    if (st_merge) begin
      for (int b = 0; b < LANES; b++) begin
        if (bus.i_st_mask[b]) begin
          ent_d[newest_idx].data[8*b +: 8] = bus.i_st_data[8*b +: 8];
        end else begin
          ent_d[newest_idx].data[8*b +: 8] = ent_q[newest_idx].data[8*b +: 8];
        end
      end
      ent_d[newest_idx].mask = ent_q[newest_idx].mask | bus.i_st_mask;
    end else begin
      ent_d[newest_idx] = ent_d[newest_idx];
    end
`endif
    count_d = count_q + CW'(st_alloc) - CW'(cm_fire);
  end

  // Split entries into per-field vectors for the lane selector.
  always_comb begin
    ent_valid = '0;
    ent_waddr = '0;
    ent_data  = '0;
    ent_mask  = '0;
    for (int i = 0; i < N_LINES; i++) begin
      ent_valid[i] = ent_q[i].valid;
      ent_waddr[i] = ent_q[i].waddr;
      ent_data[i]  = ent_q[i].data;
      ent_mask[i]  = ent_q[i].mask;
    end
  end

  stb_fwd_sel #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .N_LINES    (N_LINES)
  ) u_sel (
    .valid_i    (ent_valid),
    .waddr_i    (ent_waddr),
    .data_i     (ent_data),
    .mask_i     (ent_mask),
    .head_i     (head_q),
    .ld_waddr_i (ld_waddr),
    .covered_o  (fwd_cov),
    .data_o     (fwd_data)
  );

  // Load probe result: only lanes both requested and matched carry data.
  always_comb begin
    ld_cov     = fwd_cov & bus.i_ld_mask;
    ld_hit     = 1'b0;
    ld_partial = 1'b0;
    ld_data    = '0;
    if (bus.i_ld_valid) begin
      ld_hit     = (bus.i_ld_mask != '0) && (ld_cov == bus.i_ld_mask);
      ld_partial = (ld_cov != '0) && (ld_cov != bus.i_ld_mask);
      for (int b = 0; b < LANES; b++) begin
        if (ld_cov[b]) begin
          ld_data[8*b +: 8] = fwd_data[8*b +: 8];
        end else begin
          ld_data[8*b +: 8] = 8'h00;
        end
      end
    end else begin
      ld_hit     = 1'b0;
      ld_partial = 1'b0;
      ld_data    = '0;
    end
  end

  assign bus.o_st_ready   = st_ready;
  assign bus.o_ld_hit     = ld_hit;
  assign bus.o_ld_partial = ld_partial;
  assign bus.o_ld_data    = ld_data;
  assign bus.o_cm_valid   = head_ent.valid;
  assign bus.o_cm_addr    = head_ent.waddr << LANE_SHIFT;
  assign bus.o_cm_data    = head_ent.data;
  assign bus.o_cm_mask    = head_ent.mask;
  assign bus.o_empty      = (count_q == '0);
  assign bus.o_count      = count_q;
endmodule

// File: tb/tb_stb_fwd.sv
// Self-checking bench for stb_fwd: a queue-based reference of the store buffer
// predicts ready, commit payload, occupancy and forwarded load data.
module tb_stb_fwd;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NL = 4;
  localparam int LN = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stb_fwd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_LINES(NL)) bus();

  stb_fwd #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_LINES(NL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [AW-1:0] wa;
    logic [DW-1:0] d;
    logic [LN-1:0] m;
  } ent_t;

  ent_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference: does the incoming store merge into the newest pending store?
  function automatic bit ref_merge();
`ifdef STB_COALESCE_EN
    return (q.size() > 0) && (q[q.size()-1].wa == bus.i_st_addr / LN) &&
           !((q.size() == 1) && bus.i_cm_ready);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit ref_ready();
    return !bus.i_fence && ((q.size() < NL) || ref_merge());
  endfunction

  // Reference forwarding: newest store wins per requested byte.
  function automatic void ref_load(input logic [AW-1:0] a, input logic [LN-1:0] m,
                                  output logic hit, output logic part, output logic [DW-1:0] d);
    logic [LN-1:0] cov;
    cov = '0;
    d   = '0;
    for (int b = 0; b < LN; b++) begin
      if (m[b]) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].wa == a / LN && q[i].m[b]) begin
            d[8*b +: 8] = q[i].d[8*b +: 8];
            cov[b] = 1'b1;
            break;
          end
        end
      end
    end
    hit  = (m != '0) && (cov == m);
    part = (cov != '0) && (cov != m);
  endfunction

  // Advance one clock edge and update the reference with what that edge does.
  task automatic tick();
    logic [AW-1:0] wa;
    bit rdy, cf, mg, al;
    ent_t e;
    wa  = bus.i_st_addr / LN;
    rdy = ref_ready();
    cf  = bus.i_cm_ready && (q.size() != 0);
    mg  = bus.i_st_valid && rdy && ref_merge();
    al  = bus.i_st_valid && rdy && !mg;
    e   = '{wa, bus.i_st_data, bus.i_st_mask};
    @(posedge clk);
    if (cf) void'(q.pop_front());
    if (mg) begin
      ent_t n;
      n = q[q.size()-1];
      for (int b = 0; b < LN; b++) if (e.m[b]) n.d[8*b +: 8] = e.d[8*b +: 8];
      n.m = n.m | e.m;
      q[q.size()-1] = n;
    end
    if (al) q.push_back(e);
    #1;
  endtask

  task automatic idle();
    bus.i_st_valid = 1'b0; bus.i_st_addr = '0; bus.i_st_data = '0; bus.i_st_mask = '0;
    bus.i_ld_valid = 1'b0; bus.i_ld_addr = '0; bus.i_ld_mask = '0;
    bus.i_cm_ready = 1'b0; bus.i_fence = 1'b0;
  endtask

  task automatic drain();
    idle();
    bus.i_cm_ready = 1'b1;
    repeat (NL + 1) tick();
    bus.i_cm_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (bus.o_st_ready !== 1'b1) begin n_bad++; $display("FAIL rst_st_ready: got %b expected 1", bus.o_st_ready); end
    n_cmp++; if (bus.o_cm_valid !== 1'b0) begin n_bad++; $display("FAIL rst_cm_valid: got %b expected 0", bus.o_cm_valid); end
    n_cmp++; if (bus.o_empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b expected 1", bus.o_empty); end
    n_cmp++; if (bus.o_count !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d expected 0", bus.o_count); end
    n_cmp++; if ({bus.o_ld_hit, bus.o_ld_partial, bus.o_ld_data} !== 34'd0) begin n_bad++; $display("FAIL rst_ld_idle: got %b %b %h expected 0 0 0", bus.o_ld_hit, bus.o_ld_partial, bus.o_ld_data); end
    bus.i_ld_valid = 1'b1; bus.i_ld_addr = 32'h10; bus.i_ld_mask = 4'hF;
    #1;
    n_cmp++; if ({bus.o_ld_hit, bus.o_ld_partial, bus.o_ld_data} !== 34'd0) begin n_bad++; $display("FAIL rst_ld_probe: got %b %b %h expected 0 0 0", bus.o_ld_hit, bus.o_ld_partial, bus.o_ld_data); end
    tick();
  endtask

  task automatic test_fwd_full();
    idle();
    bus.i_st_valid = 1'b1; bus.i_st_addr = 32'h10; bus.i_st_data = 32'hAABBCCDD; bus.i_st_mask = 4'hF;
    bus.i_ld_valid = 1'b1; bus.i_ld_addr = 32'h10; bus.i_ld_mask = 4'hF;
    @(negedge clk);
    n_cmp++; if (bus.o_ld_hit !== 1'b0) begin n_bad++; $display("FAIL same_cycle_invisible: got hit %b expected 0", bus.o_ld_hit); end
    tick();
    bus.i_st_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.o_ld_hit !== 1'b1) begin n_bad++; $display("FAIL full_hit: got %b expected 1", bus.o_ld_hit); end
    n_cmp++; if (bus.o_ld_data !== 32'hAABBCCDD) begin n_bad++; $display("FAIL full_data: got %h expected aabbccdd", bus.o_ld_data); end
    n_cmp++; if (bus.o_count !== 3'd1) begin n_bad++; $display("FAIL full_count: got %0d expected 1", bus.o_count); end
    tick();
  endtask

  task automatic test_partial();
    drain();
    bus.i_st_valid = 1'b1; bus.i_st_addr = 32'h20; bus.i_st_data = 32'h00001122; bus.i_st_mask = 4'h3;
    tick();
    bus.i_st_valid = 1'b0;
    bus.i_ld_valid = 1'b1; bus.i_ld_addr = 32'h20; bus.i_ld_mask = 4'hF;
    @(negedge clk);
    n_cmp++; if (bus.o_ld_partial !== 1'b1) begin n_bad++; $display("FAIL partial_flag: got %b expected 1", bus.o_ld_partial); end
    n_cmp++; if (bus.o_ld_hit !== 1'b0) begin n_bad++; $display("FAIL partial_hit: got %b expected 0", bus.o_ld_hit); end
    bus.i_ld_mask = 4'h1;
    #1;
    n_cmp++; if (bus.o_ld_hit !== 1'b1 || bus.o_ld_partial !== 1'b0) begin n_bad++; $display("FAIL lane0_hit: got hit %b partial %b expected 1 0", bus.o_ld_hit, bus.o_ld_partial); end
    n_cmp++; if (bus.o_ld_data !== 32'h00000022) begin n_bad++; $display("FAIL lane0_data: got %h expected 00000022", bus.o_ld_data); end
    tick();
  endtask

  task automatic test_coalesce();
    logic [2:0] exp_cnt;
`ifdef STB_COALESCE_EN
    exp_cnt = 3'd1;
`else
    exp_cnt = 3'd2;
`endif
    drain();
    bus.i_st_valid = 1'b1; bus.i_st_addr = 32'h30; bus.i_st_data = 32'h11111111; bus.i_st_mask = 4'hF;
    tick();
    bus.i_st_data = 32'h22220000; bus.i_st_mask = 4'hC;
    tick();
    bus.i_st_valid = 1'b0;
    bus.i_ld_valid = 1'b1; bus.i_ld_addr = 32'h30; bus.i_ld_mask = 4'hF;
    @(negedge clk);
    n_cmp++; if (bus.o_ld_data !== 32'h22221111 || bus.o_ld_hit !== 1'b1) begin n_bad++; $display("FAIL youngest_wins: got %h hit %b expected 22221111 1", bus.o_ld_data, bus.o_ld_hit); end
    n_cmp++; if (bus.o_count !== exp_cnt) begin n_bad++; $display("FAIL coalesce_count: got %0d expected %0d", bus.o_count, exp_cnt); end
    tick();
  endtask

  task automatic test_full();
    logic [31:0] a;
    drain();
    for (int i = 0; i < 5; i++) begin
      bus.i_st_valid = 1'b1; bus.i_st_addr = 32'h40 + 32'(4 * i); bus.i_st_data = $urandom; bus.i_st_mask = 4'hF;
      @(negedge clk);
      n_cmp++; if (bus.o_st_ready !== (i < 4)) begin n_bad++; $display("FAIL fill_ready[%0d]: got %b expected %b", i, bus.o_st_ready, (i < 4)); end
      tick();
    end
    bus.i_st_addr = 32'h80; bus.i_cm_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.o_count !== 3'd4) begin n_bad++; $display("FAIL full_count4: got %0d expected 4", bus.o_count); end
    n_cmp++; if (bus.o_st_ready !== 1'b0) begin n_bad++; $display("FAIL no_bypass: got %b expected 0", bus.o_st_ready); end
    n_cmp++; if (bus.o_cm_valid !== 1'b1 || bus.o_cm_addr !== 32'h40) begin n_bad++; $display("FAIL first_commit: got %b %h expected 1 00000040", bus.o_cm_valid, bus.o_cm_addr); end
    tick();
    bus.i_st_valid = 1'b0; bus.i_cm_ready = 1'b0;
    @(negedge clk);
    a = 32'h44;
    n_cmp++; if (bus.o_count !== 3'd3 || bus.o_cm_addr !== a) begin n_bad++; $display("FAIL after_commit: got %0d %h expected 3 %h", bus.o_count, bus.o_cm_addr, a); end
    tick();
  endtask

  task automatic test_wrap_random();
    logic eh, ep;
    logic [DW-1:0] ed;
    drain();
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 30; c++) begin
        if (ph % 2 == 0) begin
          bus.i_st_valid = ($urandom_range(0, 3) != 0);
          bus.i_cm_ready = ($urandom_range(0, 3) == 0);
        end else begin
          bus.i_st_valid = ($urandom_range(0, 3) == 0);
          bus.i_cm_ready = ($urandom_range(0, 1) == 1);
        end
        bus.i_st_addr  = 32'h100 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
        bus.i_st_data  = $urandom;
        bus.i_st_mask  = 4'($urandom_range(1, 15));
        bus.i_ld_valid = ($urandom_range(0, 3) != 0);
        bus.i_ld_addr  = 32'h100 + 32'(4 * $urandom_range(0, 3));
        bus.i_ld_mask  = 4'($urandom_range(0, 15));
        @(negedge clk);
        ref_load(bus.i_ld_addr, bus.i_ld_mask, eh, ep, ed);
        if (!bus.i_ld_valid) begin eh = 1'b0; ep = 1'b0; ed = '0; end
        n_cmp++; if (bus.o_st_ready !== ref_ready()) begin n_bad++; $display("FAIL rnd_ready[%0d.%0d]: got %b expected %b", ph, c, bus.o_st_ready, ref_ready()); end
        n_cmp++; if (bus.o_count !== 3'(q.size()) || bus.o_empty !== (q.size() == 0)) begin n_bad++; $display("FAIL rnd_count[%0d.%0d]: got %0d/%b expected %0d", ph, c, bus.o_count, bus.o_empty, q.size()); end
        n_cmp++; if (bus.o_cm_valid !== (q.size() != 0)) begin n_bad++; $display("FAIL rnd_cm_valid[%0d.%0d]: got %b expected %b", ph, c, bus.o_cm_valid, (q.size() != 0)); end
        if (q.size() != 0) begin
          n_cmp++;
          if (bus.o_cm_addr !== q[0].wa * LN || bus.o_cm_data !== q[0].d || bus.o_cm_mask !== q[0].m) begin
            n_bad++; $display("FAIL rnd_commit[%0d.%0d]: got %h %h %h expected %h %h %h", ph, c, bus.o_cm_addr, bus.o_cm_data, bus.o_cm_mask, q[0].wa * LN, q[0].d, q[0].m);
          end
        end
        n_cmp++; if (bus.o_ld_hit !== eh || bus.o_ld_partial !== ep || bus.o_ld_data !== ed) begin n_bad++; $display("FAIL rnd_load[%0d.%0d]: got %b %b %h expected %b %b %h", ph, c, bus.o_ld_hit, bus.o_ld_partial, bus.o_ld_data, eh, ep, ed); end
        tick();
      end
    end
  endtask

  task automatic test_fence();
    int cyc;
    bit done;
    drain();
    for (int i = 0; i < 2; i++) begin
      bus.i_st_valid = 1'b1; bus.i_st_addr = 32'h200 + 32'(4 * i); bus.i_st_data = $urandom; bus.i_st_mask = 4'hF;
      tick();
    end
    bus.i_st_addr = 32'h208; bus.i_fence = 1'b1; bus.i_cm_ready = 1'b1;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 10) begin
      @(negedge clk);
      n_cmp++; if (bus.o_st_ready !== 1'b0) begin n_bad++; $display("FAIL fence_ready[%0d]: got %b expected 0", cyc, bus.o_st_ready); end
      if (bus.o_empty) done = 1'b1;
      else begin tick(); cyc++; end
    end
    n_cmp++; if (!done || cyc != 2) begin n_bad++; $display("FAIL fence_drain: got empty %b after %0d commits expected 1 after 2", done, cyc); end
    bus.i_fence = 1'b0;
    #1;
    n_cmp++; if (bus.o_st_ready !== 1'b1) begin n_bad++; $display("FAIL fence_release: got %b expected 1", bus.o_st_ready); end
    bus.i_st_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    drain();
    for (int i = 0; i < 3; i++) begin
      bus.i_st_valid = 1'b1; bus.i_st_addr = 32'h300 + 32'(4 * i); bus.i_st_data = $urandom; bus.i_st_mask = 4'hF;
      tick();
    end
    bus.i_st_valid = 1'b0; bus.i_cm_ready = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++; if (bus.o_count !== 3'(q.size())) begin n_bad++; $display("FAIL mid_count: got %0d expected %0d", bus.o_count, q.size()); end
    rst = 1'b1;
    #1;
    q.delete();
    n_cmp++; if (bus.o_cm_valid !== 1'b0 || bus.o_count !== 3'd0 || bus.o_empty !== 1'b1) begin n_bad++; $display("FAIL async_reset: got %b %0d %b expected 0 0 1", bus.o_cm_valid, bus.o_count, bus.o_empty); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.o_cm_valid !== 1'b0 || bus.o_count !== 3'd0) begin n_bad++; $display("FAIL post_reset: got %b %0d expected 0 0", bus.o_cm_valid, bus.o_count); end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_fwd_full();
    test_partial();
    test_coalesce();
    test_full();
    test_wrap_random();
    test_fence();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
